// File: rtl/alu_exec_stage.sv
// Purpose: registered ALU execute stage; computes result/zero/ovf/illegal and queues it with the tag.
// Latency: 1 cycle (an op accepted at edge N is presented in the cycle after N); 1 op/cycle sustained.
// Backpressure: 2-entry queue; in_ready = not full and never depends combinationally on out_ready.
// Ports: clk/rst_n; in_valid/in_ready with alu_op, op_a, op_b, in_tag;
//        out_valid/out_ready with result, zero, ovf, illegal, out_tag (driven from the queue head).
module alu_exec_stage #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam int MSB = WIDTH - 1;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             zero;
        logic             ovf;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } rec_t;

    rec_t             rec_d;
    rec_t             mem_q [2];
    rec_t             head;
    logic             head_q;
    logic             tail_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             slt;

    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;
    assign slt  = $signed(op_a) < $signed(op_b);

    always_comb begin
        rec_d     = '0;
        rec_d.tag = in_tag;
        case (alu_op)
            3'b000: rec_d.res = op_a & op_b;
            3'b001: rec_d.res = op_a | op_b;
            3'b010: begin
                rec_d.res = sum;
                // Same-sign operands whose sum flips sign.
                rec_d.ovf = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
            end
            3'b011: rec_d.res = op_a ^ op_b;
            3'b100: rec_d.res = ~(op_a | op_b);
            3'b110: begin
                rec_d.res = diff;
                // Opposite-sign operands whose difference takes b's sign.
                rec_d.ovf = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
            end
            3'b111: rec_d.res = {{(WIDTH-1){1'b0}}, slt};
            default: rec_d.ill = 1'b1;   // 3'b101: result stays 0
        endcase
        rec_d.zero = (rec_d.res == '0);
    end

    // A full queue refuses the push even if it pops this cycle, so in_ready
    // depends only on registered state.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                mem_q[tail_q] <= rec_d;
                tail_q        <= ~tail_q;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            count_q <= count_d;
        end
    end

    assign head    = mem_q[head_q];
    assign result  = head.res;
    assign zero    = head.zero;
    assign ovf     = head.ovf;
    assign illegal = head.ill;
    assign out_tag = head.tag;

endmodule
